// File: rtl/afe_buf_udma_reader.sv
// Read side of the AFE sample buffer: issues buffer reads against a credit
// budget and delivers the returning SRAM words to the uDMA RX channel.
module afe_buf_udma_reader #(
    parameter int DWIDTH     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int CWIDTH     = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          en_i,
    input  logic                          clr_i,
    input  logic                          buf_read_valid_i,
    output logic                          buf_vtransfer_o,
    input  logic [DWIDTH-1:0]             mem_rdata_i,
    output logic [DWIDTH-1:0]             udma_data_o,
    output logic                          udma_valid_o,
    input  logic                          udma_ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic [CWIDTH-1:0]             words_done_o,
    output logic                          busy_o
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int LW  = AW + 1;
    localparam int LW1 = LW + 1;
    localparam logic [LW-1:0] FULL_C   = LW'(FIFO_DEPTH);
    localparam logic [LW:0]   CREDIT_C = LW1'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [LW-1:0]     count_q, count_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic              inflight_q, inflight_d;
    logic [CWIDTH-1:0] words_q, words_d;
    logic [DWIDTH-1:0] mem_q [FIFO_DEPTH];

    logic          issue;
    logic          push;
    logic          pop;
    logic          empty;
    logic          full;
    logic [LW:0]   credit;

    // A read in flight already owns a FIFO slot, so it counts against the budget.
    assign credit = {1'b0, count_q} + {{LW{1'b0}}, inflight_q};
    assign empty  = (count_q == '0);
    assign full   = (count_q == FULL_C);
    assign issue  = (state_q == RUN) & en_i & buf_read_valid_i & ~clr_i & (credit < CREDIT_C);
    assign push   = inflight_q & ~clr_i;
    assign pop    = ~empty & udma_ready_i;

    always_comb begin
        state_d    = state_q;
        words_d    = words_q;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        inflight_d = issue;

        if (pop) begin
            words_d  = words_q + CWIDTH'(1);
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + LW'(1);
            2'b01:   count_d = count_q - LW'(1);
            default: count_d = count_q;
        endcase

        unique case (state_q)
            IDLE: begin
                if (en_i) begin
                    state_d = RUN;
                    words_d = '0;
                end
            end
            RUN: begin
                if (!en_i) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (en_i) begin
                    state_d = RUN;
                end else if (empty && !inflight_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Flush overrides everything, including a read returning this cycle.
        if (clr_i) begin
            state_d    = IDLE;
            words_d    = '0;
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            inflight_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            inflight_q <= 1'b0;
            words_q    <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            inflight_q <= inflight_d;
            words_q    <= words_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= mem_rdata_i;
        end
    end

    push_into_full_a: assert property (@(posedge clk_i) disable iff (rst_i) !(push && full));

    assign buf_vtransfer_o = issue;
    assign udma_valid_o    = ~empty;
    assign udma_data_o     = empty ? '0 : mem_q[rd_ptr_q];
    assign fifo_level_o    = count_q;
    assign words_done_o    = words_q;
    assign busy_o          = (state_q != IDLE);

endmodule

// File: tb/tb_afe_buf_udma_reader.sv
// Directed bench for afe_buf_udma_reader: cycle table for streaming plus
// hand-written sequences for backpressure, drain, flush, gaps, wrap and reset.
module tb_afe_buf_udma_reader;

    logic        clk;
    logic        rst_i;
    logic        en_i;
    logic        clr_i;
    logic        buf_read_valid_i;
    logic        buf_vtransfer_o;
    logic [31:0] mem_rdata_i;
    logic [31:0] udma_data_o;
    logic        udma_valid_o;
    logic        udma_ready_i;
    logic [2:0]  fifo_level_o;
    logic [3:0]  words_done_o;
    logic        busy_o;

    int checks = 0;
    int errors = 0;
    int sram_idx;
    int vt_seen;

    afe_buf_udma_reader #(
        .DWIDTH(32),
        .FIFO_DEPTH(4),
        .CWIDTH(4)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_i),
        .en_i(en_i),
        .clr_i(clr_i),
        .buf_read_valid_i(buf_read_valid_i),
        .buf_vtransfer_o(buf_vtransfer_o),
        .mem_rdata_i(mem_rdata_i),
        .udma_data_o(udma_data_o),
        .udma_valid_o(udma_valid_o),
        .udma_ready_i(udma_ready_i),
        .fifo_level_o(fifo_level_o),
        .words_done_o(words_done_o),
        .busy_o(busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Buffer SRAM stand-in: k-th read returns 0x100+k one cycle later, junk otherwise.
    always @(posedge clk) begin
        if (rst_i) begin
            sram_idx    <= 0;
            mem_rdata_i <= 32'hBAD0_0000;
        end else if (buf_vtransfer_o) begin
            mem_rdata_i <= 32'h100 + 32'(sram_idx);
            sram_idx    <= sram_idx + 1;
        end else begin
            mem_rdata_i <= 32'hBAD0_0000;
        end
    end

    typedef struct {
        logic        en;
        logic        clr;
        logic        brv;
        logic        rdy;
        logic        vt;
        logic        vld;
        logic [31:0] data;
        logic [2:0]  lvl;
        logic [3:0]  words;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic en, input logic clr, input logic brv, input logic rdy);
        en_i = en;
        clr_i = clr;
        buf_read_valid_i = brv;
        udma_ready_i = rdy;
        @(negedge clk);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        en_i = 1'b0;
        clr_i = 1'b0;
        buf_read_valid_i = 1'b0;
        udma_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;
    endtask

    task automatic drain(input logic [31:0] first, input int n, input logic en, input logic brv,
                         input string name);
        logic [31:0] exp;
        int got;
        exp = first;
        got = 0;
        vt_seen = 0;
        for (int i = 0; i < 20; i++) begin
            drive(en, 1'b0, brv, 1'b1);
            if (udma_valid_o) begin
                chk({name, " data"}, udma_data_o, exp);
                exp = exp + 32'd1;
                got++;
            end
            if (buf_vtransfer_o) vt_seen++;
            nxt();
        end
        chk({name, " words delivered"}, 32'(got), 32'(n));
    endtask

    initial begin
        int pulses;
        int issued;
        int cyc;

        // Streaming table: issue at c1..c8, data at c3..c10.
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   3'd0, 4'd0};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,   3'd0, 4'd0};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,   3'd0, 4'd0};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h100, 3'd1, 4'd0};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h101, 3'd1, 4'd1};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h102, 3'd1, 4'd2};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h103, 3'd1, 4'd3};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h104, 3'd1, 4'd4};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h105, 3'd1, 4'd5};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h106, 3'd1, 4'd6};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h107, 3'd1, 4'd7};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   3'd0, 4'd8};

        do_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset vtransfer", 32'(buf_vtransfer_o), 32'd0);
        chk("reset valid", 32'(udma_valid_o), 32'd0);
        chk("reset data", udma_data_o, 32'd0);
        chk("reset level", 32'(fifo_level_o), 32'd0);
        chk("reset words", 32'(words_done_o), 32'd0);
        chk("reset busy", 32'(busy_o), 32'd0);
        nxt();

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].en, vecs[i].clr, vecs[i].brv, vecs[i].rdy);
            chk($sformatf("stream c%0d vtransfer", i), 32'(buf_vtransfer_o), 32'(vecs[i].vt));
            chk($sformatf("stream c%0d valid", i), 32'(udma_valid_o), 32'(vecs[i].vld));
            if (vecs[i].vld) chk($sformatf("stream c%0d data", i), udma_data_o, vecs[i].data);
            chk($sformatf("stream c%0d level", i), 32'(fifo_level_o), 32'(vecs[i].lvl));
            chk($sformatf("stream c%0d words", i), 32'(words_done_o), 32'(vecs[i].words));
            nxt();
        end

        // Backpressure: credit allows exactly FIFO_DEPTH outstanding words.
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b0);
            if (buf_vtransfer_o) pulses++;
            nxt();
        end
        chk("bp pulses", 32'(pulses), 32'd4);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        chk("bp level", 32'(fifo_level_o), 32'd4);
        chk("bp vtransfer held", 32'(buf_vtransfer_o), 32'd0);
        chk("bp head stable", udma_data_o, 32'h108);
        nxt();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b1);
            chk($sformatf("bp release data%0d", i), udma_data_o, 32'h108 + 32'(i));
            chk($sformatf("bp release vtransfer%0d", i), 32'(buf_vtransfer_o), (i == 0) ? 32'd0 : 32'd1);
            nxt();
        end
        drain(32'h10C, 3, 1'b1, 1'b0, "bp tail");
        chk("bp words", 32'(words_done_o), 32'd15);

        // Disable one cycle after an issue, with two words already queued.
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        nxt();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b0);
            chk($sformatf("dis issue%0d", i), 32'(buf_vtransfer_o), 32'd1);
            nxt();
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        chk("dis no issue", 32'(buf_vtransfer_o), 32'd0);
        chk("dis level before land", 32'(fifo_level_o), 32'd2);
        nxt();
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        chk("dis busy in drain", 32'(busy_o), 32'd1);
        chk("dis level landed", 32'(fifo_level_o), 32'd3);
        nxt();
        drain(32'h100, 3, 1'b0, 1'b1, "dis");
        chk("dis vtransfer during drain", 32'(vt_seen), 32'd0);
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        chk("dis idle", 32'(busy_o), 32'd0);
        nxt();

        // Flush with three queued and one in flight.
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        nxt();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 1'b1, (i < 3) ? 1'b1 : 1'b0);
            nxt();
        end
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        chk("clr pre level", 32'(fifo_level_o), 32'd3);
        chk("clr pre words", 32'(words_done_o), 32'd1);
        chk("clr vtransfer", 32'(buf_vtransfer_o), 32'd0);
        nxt();
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        chk("clr valid", 32'(udma_valid_o), 32'd0);
        chk("clr level", 32'(fifo_level_o), 32'd0);
        chk("clr words", 32'(words_done_o), 32'd0);
        chk("clr busy", 32'(busy_o), 32'd0);
        nxt();
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b1);
            if (udma_valid_o) pulses++;
            nxt();
        end
        chk("clr late data suppressed", 32'(pulses), 32'd0);
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        chk("clr forces vtransfer low", 32'(buf_vtransfer_o), 32'd0);
        nxt();

        // Buffer empty on alternate cycles.
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        nxt();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, (i % 2 == 0) ? 1'b1 : 1'b0, 1'b0);
            chk($sformatf("gap vtransfer%0d", i), 32'(buf_vtransfer_o), (i % 2 == 0) ? 32'd1 : 32'd0);
            nxt();
        end
        drain(32'h100, 2, 1'b1, 1'b0, "gap");

        // Counter wrap with CWIDTH = 4.
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        nxt();
        issued = 0;
        cyc = 0;
        while (issued < 17 && cyc < 100) begin
            drive(1'b1, 1'b0, 1'b1, 1'b1);
            if (buf_vtransfer_o) issued++;
            nxt();
            cyc++;
        end
        chk("wrap issue budget", 32'(issued), 32'd17);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b1);
            nxt();
        end
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        chk("wrap words", 32'(words_done_o), 32'd1);
        chk("wrap level", 32'(fifo_level_o), 32'd0);
        nxt();

        // Asynchronous reset between clock edges.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b0);
            nxt();
        end
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        chk("areset pre level", 32'(fifo_level_o), 32'd2);
        #2;
        rst_i = 1'b1;
        #1;
        chk("areset vtransfer", 32'(buf_vtransfer_o), 32'd0);
        chk("areset valid", 32'(udma_valid_o), 32'd0);
        chk("areset data", udma_data_o, 32'd0);
        chk("areset level", 32'(fifo_level_o), 32'd0);
        chk("areset words", 32'(words_done_o), 32'd0);
        chk("areset busy", 32'(busy_o), 32'd0);
        nxt();
        rst_i = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
        $fatal(1, "timeout");
    end

endmodule
